// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment definitions for the display driver and reader.
// Holds the active-low segment codebook, the anode-to-slot encodings and the
// blank pattern so both sides of the display link agree on a single table.
package sseg_pkg;

    localparam int unsigned NUM_SLOTS = 4;

    // Active-low segment pattern (g..a) with every segment dark.
    localparam logic [6:0] BLANK_SEG = 7'h7F;

    // Active-low anode selects: exactly one low bit picks a slot.
    localparam logic [3:0] AN_SLOT0 = 4'b0111;
    localparam logic [3:0] AN_SLOT1 = 4'b1011;
    localparam logic [3:0] AN_SLOT2 = 4'b1101;
    localparam logic [3:0] AN_SLOT3 = 4'b1110;
    localparam logic [3:0] AN_IDLE  = 4'b1111;

    // Entry [n] is the active-low g..a pattern that shows hex digit n.
    localparam logic [15:0][6:0] SEG_CODEBOOK = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // One-hot slot for a legal single-anode select, zero for idle or illegal.
    function automatic logic [3:0] an_to_slot_hot(input logic [3:0] an);
        logic [3:0] hot;
        hot = 4'b0000;
        case (an)
            AN_SLOT0: hot = 4'b0001;
            AN_SLOT1: hot = 4'b0010;
            AN_SLOT2: hot = 4'b0100;
            AN_SLOT3: hot = 4'b1000;
            default:  hot = 4'b0000;
        endcase
        return hot;
    endfunction

endpackage

// File: rtl/seg_to_digit.sv
// seg_to_digit: combinational reverse lookup of an active-low 7-segment
// pattern into its hex digit; hit is low for any pattern outside the codebook.
module seg_to_digit
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] digit
);

    // Search the codebook; patterns are unique so at most one entry matches.
    always_comb begin
        hit   = 1'b0;
        digit = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODEBOOK[i]) begin
                hit   = 1'b1;
                digit = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_reader.sv
// sseg_reader: samples the multiplexed active-low anode/cathode lines of a
// seven-segment display, waits for each slot to hold steady, and decodes the
// cathodes back into four hex digits with valid/error status.
// Optional feature macro: SSEG_READER_DP_EN (capture decimal points into dp).
module sseg_reader
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] SSEG_AN,
    input  logic [7:0] SSEG_CA,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp,
    output logic [3:0] valid,
    output logic [3:0] seg_err,
    output logic       an_err,
    output logic       frame_done
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]    an_q;
    logic [7:0]    ca_q;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    seen;

    logic [3:0]    slot_hot;
    logic          an_idle;
    logic          an_illegal;
    logic          cap_point;
    logic          capture;
    logic          expire;
    logic          seg_hit;
    logic [3:0]    seg_digit;

    seg_to_digit u_seg_to_digit (
        .seg   (ca_q[6:0]),
        .hit   (seg_hit),
        .digit (seg_digit)
    );

    assign slot_hot   = an_to_slot_hot(an_q);
    assign an_idle    = (an_q == AN_IDLE);
    assign an_illegal = !an_idle && (slot_hot == 4'b0000);

    // The counter sits at STABLE_CYCLES-1 for exactly one cycle per stable
    // period, so this single compare gives one capture opportunity per period.
    assign cap_point  = (stab_cnt == SW'(STABLE_CYCLES - 1));
    assign capture    = cap_point && (slot_hot != 4'b0000);

    // A capture on the expiry cycle suppresses the expiry entirely.
    assign expire     = !capture && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Sample the pins every cycle and count how long the sample has held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q     <= AN_IDLE;
            ca_q     <= 8'hFF;
            stab_cnt <= '0;
        end else begin
            an_q <= SSEG_AN;
            ca_q <= SSEG_CA;
            if ({SSEG_AN, SSEG_CA} != {an_q, ca_q}) begin
                stab_cnt <= '0;
            end else if (stab_cnt != SW'(STABLE_CYCLES)) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // Count cycles since the last capture, saturating once expired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (capture) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Apply captures to the digit/status registers and track frame completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit0     <= 4'h0;
            digit1     <= 4'h0;
            digit2     <= 4'h0;
            digit3     <= 4'h0;
            valid      <= 4'b0000;
            seg_err    <= 4'b0000;
            an_err     <= 1'b0;
            frame_done <= 1'b0;
            seen       <= 4'b0000;
        end else begin
            frame_done <= 1'b0;
            if (cap_point && an_illegal) begin
                an_err <= 1'b1;
            end
            if (capture) begin
                if (seg_hit) begin
                    if (slot_hot[0]) digit0 <= seg_digit;
                    if (slot_hot[1]) digit1 <= seg_digit;
                    if (slot_hot[2]) digit2 <= seg_digit;
                    if (slot_hot[3]) digit3 <= seg_digit;
                    valid   <= valid | slot_hot;
                    seg_err <= seg_err & ~slot_hot;
                end else begin
                    seg_err <= seg_err | slot_hot;
                end
                // The completing capture counts toward the frame before the clear.
                if ((seen | slot_hot) == 4'b1111) begin
                    seen       <= 4'b0000;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen | slot_hot;
                end
            end else if (expire) begin
                valid <= 4'b0000;
                seen  <= 4'b0000;
            end
        end
    end

`ifdef SSEG_READER_DP_EN
    // Latch the decimal point of each legally decoded slot (cathode is active-low).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp <= 4'b0000;
        end else if (capture && seg_hit) begin
            dp <= (dp & ~slot_hot) | (slot_hot & {4{~ca_q[7]}});
        end
    end
`else
    assign dp = 4'b0000;
`endif

endmodule

// File: tb/tb_sseg_reader.sv
// tb_sseg_reader: directed, table-driven bench for sseg_reader with short
// timeout so expiry can be exercised.
module tb_sseg_reader;

    localparam int unsigned STABLE  = 4;
    localparam int unsigned TIMEOUT = 50;

    logic       clk;
    logic       rst_n;
    logic [3:0] SSEG_AN;
    logic [7:0] SSEG_CA;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] dp, valid, seg_err;
    logic       an_err, frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int fd_count = 0;
    logic [3:0] last_fd_d3 = 4'h0;

    sseg_reader #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SSEG_AN    (SSEG_AN),
        .SSEG_CA    (SSEG_CA),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .dp         (dp),
        .valid      (valid),
        .seg_err    (seg_err),
        .an_err     (an_err),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame pulses and note which slot3 digit is visible alongside each.
    always @(negedge clk) begin
        if (frame_done) begin
            fd_count   = fd_count + 1;
            last_fd_d3 = digit3;
        end
    end

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  ca;
        int          cyc;
        logic [15:0] dig;
        logic [3:0]  vld;
        logic [3:0]  serr;
        logic        aerr;
        int          frames;
        logic [3:0]  fd_d3;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //            an       ca     cyc  digits    valid    serr     aerr frm fd_d3
        tbl[0]  = '{4'b1011, 8'hF9, 10, 16'h0010, 4'b0011, 4'b0000, 1'b0, 0, 4'h0};
        tbl[1]  = '{4'b1101, 8'hA4, 10, 16'h0210, 4'b0111, 4'b0000, 1'b0, 0, 4'h0};
        tbl[2]  = '{4'b1110, 8'hB0, 10, 16'h3210, 4'b1111, 4'b0000, 1'b0, 1, 4'h3};
        tbl[3]  = '{4'b1011, 8'hF9,  2, 16'h3210, 4'b1111, 4'b0000, 1'b0, 1, 4'h3};
        tbl[4]  = '{4'b1011, 8'hA4,  8, 16'h3220, 4'b1111, 4'b0000, 1'b0, 1, 4'h3};
        tbl[5]  = '{4'b0111, 8'h99,  3, 16'h3220, 4'b1111, 4'b0000, 1'b0, 1, 4'h3};
        tbl[6]  = '{4'b0111, 8'hC0,  2, 16'h3220, 4'b1111, 4'b0000, 1'b0, 1, 4'h3};
        tbl[7]  = '{4'b0111, 8'hC0,  6, 16'h3220, 4'b1111, 4'b0000, 1'b0, 1, 4'h3};
        tbl[8]  = '{4'b1101, 8'hFF,  8, 16'h3220, 4'b1111, 4'b0100, 1'b0, 1, 4'h3};
        tbl[9]  = '{4'b1101, 8'h8E,  8, 16'h3F20, 4'b1111, 4'b0000, 1'b0, 1, 4'h3};
        tbl[10] = '{4'b0011, 8'hF9,  8, 16'h3F20, 4'b1111, 4'b0000, 1'b1, 1, 4'h3};
        tbl[11] = '{4'b0111, 8'hC0,  8, 16'h3F20, 4'b1111, 4'b0000, 1'b1, 1, 4'h3};
        tbl[12] = '{4'b1011, 8'hF9,  8, 16'h3F10, 4'b1111, 4'b0000, 1'b1, 1, 4'h3};
        tbl[13] = '{4'b1101, 8'hA4,  8, 16'h3210, 4'b1111, 4'b0000, 1'b1, 1, 4'h3};
        tbl[14] = '{4'b1110, 8'h83,  8, 16'hB210, 4'b1111, 4'b0000, 1'b1, 2, 4'hB};

        rst_n   = 1'b0;
        SSEG_AN = 4'b1111;
        SSEG_CA = 8'hFF;
        step(3);
        check("rst digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("rst valid", valid, 4'b0000);
        check("rst seg_err", seg_err, 4'b0000);
        check("rst an_err", an_err, 1'b0);
        check("rst frame_done", frame_done, 1'b0);
        check("rst dp", dp, 4'b0000);

        // First slot: nothing before STABLE+1 edges, capture visible at STABLE+1.
        rst_n   = 1'b1;
        SSEG_AN = 4'b0111;
        SSEG_CA = 8'hC0;
        step(STABLE);
        check("first valid early", valid, 4'b0000);
        step(1);
        check("first valid", valid, 4'b0001);
        check("first digit0", digit0, 4'h0);
        check("first seg_err", seg_err, 4'b0000);
        step(1);

        for (int i = 0; i < 15; i++) begin
            SSEG_AN = tbl[i].an;
            SSEG_CA = tbl[i].ca;
            step(tbl[i].cyc);
            check($sformatf("v%0d digits", i), {digit3, digit2, digit1, digit0}, tbl[i].dig);
            check($sformatf("v%0d valid", i), valid, tbl[i].vld);
            check($sformatf("v%0d seg_err", i), seg_err, tbl[i].serr);
            check($sformatf("v%0d an_err", i), an_err, tbl[i].aerr);
            check($sformatf("v%0d frames", i), fd_count, tbl[i].frames);
            check($sformatf("v%0d frame digit3", i), last_fd_d3, tbl[i].fd_d3);
            check($sformatf("v%0d dp", i), dp, 4'b0000);
        end

        // Timeout: last capture landed 3 edges before the table ended.
        SSEG_AN = 4'b1111;
        SSEG_CA = 8'hFF;
        step(TIMEOUT - 4);
        check("tmo valid before", valid, 4'b1111);
        step(1);
        check("tmo valid at expiry", valid, 4'b0000);
        check("tmo digits kept", {digit3, digit2, digit1, digit0}, 16'hB210);

        // Reset asserted on the edge a capture would land: reset wins.
        SSEG_AN = 4'b0111;
        SSEG_CA = 8'hC0;
        step(STABLE);
        rst_n = 1'b0;
        step(1);
        check("midrst digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("midrst valid", valid, 4'b0000);
        check("midrst an_err", an_err, 1'b0);
        check("midrst frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        step(STABLE);
        check("post-rst valid early", valid, 4'b0000);
        step(1);
        check("post-rst valid", valid, 4'b0001);

`ifdef SSEG_READER_DP_EN
        SSEG_CA = 8'h40;
        step(STABLE + 2);
        check("dp0 lit", dp, 4'b0001);
        check("dp digit0", digit0, 4'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
